// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  // States in which the loader is consuming the byte stream.
  function automatic logic loading(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit words and emits a
// one-cycle word_valid strobe the cycle after the fourth byte of each word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  din,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt;
  logic [23:0]   shreg;

  // Byte being taken now completes the current word.
  assign last = (cnt == CW'(WORD_BYTES - 1));

  // Byte counter, completed-word register and write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          word_valid <= 1'b1;
          word       <= {shreg, din};
        end
      end
    end
  end

  // Leading three bytes of the word under assembly; pure data, no reset.
  always_ff @(posedge clk) begin
    if (take) shreg <= {shreg[15:0], din};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte image,
// writes it word by word into instruction RAM and releases the CPU only
// after the whole image has been written and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int IW = $clog2(DEPTH + 1);

  state_t        state, state_nx;
  logic          accept, take, launch, expire, last, last_word;
  logic [15:0]   n_words;
  logic [7:0]    len_hi, csum;
  logic [IW-1:0] len, idx;
  logic [31:0]   timer;

  assign accept    = in_valid && in_ready;
  assign take      = accept && (state == DATA);
  assign launch    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign n_words   = {len_hi, in_data};
  assign last_word = (idx == len - IW'(1));
  // An accept in the expiry cycle keeps the load alive.
  assign expire    = (TIMEOUT_CYCLES != 0) && loading(state) && !accept &&
                     (timer == 32'(TIMEOUT_CYCLES - 1));

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (launch),
    .take       (take),
    .din        (in_data),
    .last       (last),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode for the load sequence.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        if (accept)      state_nx = LEN_LO;
        else if (expire) state_nx = ERROR;
      end
      LEN_LO: begin
        if (accept) begin
          if (n_words > 16'(DEPTH))  state_nx = ERROR;
          else if (n_words == 16'd0) state_nx = CSUM;
          else                       state_nx = DATA;
        end else if (expire) begin
          state_nx = ERROR;
        end
      end
      DATA: begin
        if (take && last && last_word) state_nx = CSUM;
        else if (expire)               state_nx = ERROR;
      end
      CSUM: begin
        if (accept)      state_nx = (in_data == csum) ? DONE : ERROR;
        else if (expire) state_nx = ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      in_ready <= loading(state_nx);
      done     <= (state_nx == DONE);
      err      <= (state_nx == ERROR);
      cpu_hold <= (state_nx != DONE);
    end
  end

  // Word index, running checksum, idle timer and write address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      csum     <= '0;
      timer    <= '0;
      mem_addr <= '0;
    end else if (launch) begin
      idx   <= '0;
      csum  <= '0;
      timer <= '0;
    end else begin
      if (loading(state)) timer <= accept ? 32'd0 : timer + 32'd1;
      if (take) begin
        csum <= csum ^ in_data;
        if (last) begin
          mem_addr <= BASE_ADDR + (32'(idx) << 2);
          idx      <= idx + IW'(1);
        end
      end
    end
  end

  // Captured length bytes; pure data, no reset.
  always_ff @(posedge clk) begin
    if ((state == LEN_HI) && accept) len_hi <= in_data;
    if ((state == LEN_LO) && accept) len    <= n_words[IW-1:0];
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized image loads compared with a
// behavioural model of the stream format and the expected RAM writes.
module tb_imem_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic        mem_we, cpu_hold, done, err;
  logic [7:0]  in_data;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every RAM write must match the next expected (address, word, cycle).
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        chk("spurious_we", 32'(mem_we), 32'd0);
      end else begin
        chk("wr_addr", mem_addr, exp_addr_q.pop_front());
        chk("wr_data", mem_wdata, exp_data_q.pop_front());
        chk("wr_cycle", 32'(cyc), (exp_cyc_q.size() != 0) ? 32'(exp_cyc_q.pop_front()) : 32'hFFFF_FFFF);
      end
    end
  end

  // Reference model: expected writes and final verdict from the raw stream.
  task automatic model_load(output bit exp_done);
    int n;
    logic [7:0] x;
    n = int'({stream[0], stream[1]});
    x = 8'h00;
    exp_done = 1'b0;
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_data_q.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
    end
    for (int k = 2; k < 2 + 4 * n; k++) x = x ^ stream[k];
    exp_done = (stream[2+4*n] == x);
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] b, x;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n > DEPTH) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      x = x ^ b;
    end
    stream.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    acc = -1;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic clear_model();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic run_load(input int gap_lo, input int gap_hi, input int start_at);
    int n, nb, acc;
    bit exp_done;
    model_load(exp_done);
    n  = int'({stream[0], stream[1]});
    nb = (n > DEPTH) ? 2 : stream.size();
    do_start();
    for (int k = 0; k < nb; k++) begin
      if (k == start_at) start = 1'b1;
      send_byte(stream[k], int'($urandom_range(gap_hi, gap_lo)), acc);
      start = 1'b0;
      if (k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3) exp_cyc_q.push_back(acc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(!exp_done));
    chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    chk("ready_after", 32'(in_ready), 32'd0);
    chk("writes_left", 32'(exp_addr_q.size()), 32'd0);
    clear_model();
  endtask

  initial begin
    int acc, first, n;
    bit exp_done;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Nominal two-word image, bad checksum, then the same image with in_valid toggling.
    stream = {8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h28};
    run_load(0, 0, -1);
    stream = {8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h29};
    run_load(0, 0, -1);
    stream = {8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h28};
    run_load(1, 1, -1);

    // Oversize lengths and an empty image.
    stream = {8'h01, 8'h01};
    run_load(0, 0, -1);
    stream = {8'h00, 8'h05};
    run_load(0, 0, -1);
    stream = {8'h00, 8'h00, 8'h00};
    run_load(0, 0, -1);

    // Full depth with a start pulse in the middle of the data.
    build(DEPTH, 1'b0);
    run_load(0, 0, 7);

    // Randomized images, lengths, gaps and checksum corruption.
    for (int it = 0; it < 24; it++) begin
      n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(6, 5)) : int'($urandom_range(DEPTH, 0));
      build(n, $urandom_range(3, 0) == 0);
      run_load(0, 3, int'($urandom_range(20, 0)));
    end

    // Stream stalls after five data bytes: error exactly TMO cycles after the last accept.
    stream = {8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03, 8'h28};
    model_load(exp_done);
    do_start();
    for (int k = 0; k < 7; k++) begin
      send_byte(stream[k], 0, acc);
      if (k == 5) exp_cyc_q.push_back(acc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      if (err) begin
        first = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("timeout_cycle", 32'(first), 32'(acc + 1 + TMO));
    chk("timeout_hold", 32'(cpu_hold), 32'd1);
    chk("timeout_ready", 32'(in_ready), 32'd0);
    clear_model();

    // Asynchronous reset in the middle of the second word.
    model_load(exp_done);
    do_start();
    for (int k = 0; k < 8; k++) begin
      send_byte(stream[k], 0, acc);
      if (k == 5) exp_cyc_q.push_back(acc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear_model();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd0);
    chk("post_rst_hold", 32'(cpu_hold), 32'd1);

    // Loader recovers with a fresh load after reset.
    run_load(0, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the writable instruction memory.
- Consumes a byte stream from the serial receiver with a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and drives the instruction RAM write port at word-aligned byte addresses.
- Holds the CPU in reset until a complete, checksum-verified image has been written.

Parameters:
- DEPTH, 256, instruction RAM size in words; the RAM indexes on Address[9:2].
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
- TIMEOUT_CYCLES, 1_000_000, maximum idle gap between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts the byte this cycle
- mem_we  out  1  instruction RAM write enable, one cycle per word
- mem_addr  out  32  write byte address, BASE_ADDR + 4*index
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  holds the CPU in reset while high
- done  out  1  image loaded and verified
- err  out  1  load failed (length, checksum or timeout)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, all counters=0.
- Reset mid-load abandons the load. Words already written stay in RAM; the loader does not scrub them.
- Handshake: a byte is accepted only in a cycle where in_valid && in_ready. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
- Stream format: LEN_HI, LEN_LO (word count N, 16-bit big-endian), then N*4 data bytes (each word MSB first), then one checksum byte. The checksum is the XOR of all data bytes; the length bytes are excluded.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- IDLE -> LEN_HI on start. Clears the word index, byte counter, checksum and timer. Sets cpu_hold=1.
- LEN_HI -> LEN_LO on accept.
- LEN_LO on accept:
  - N > DEPTH -> ERROR.
  - N == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On the 4th accepted byte of a word: the counter wraps to 0 and the word index increments.
  - The next cycle asserts mem_we=1 for exactly one cycle, with mem_addr=BASE_ADDR+4*index_old and mem_wdata=assembled word.
  - After the last word's 4th byte -> CSUM. The final write still issues in the following cycle.
- CSUM on accept:
  - byte == running XOR -> DONE.
  - otherwise -> ERROR.
- DONE: done=1, cpu_hold=0.
- ERROR: err=1, cpu_hold=1.
- DONE and ERROR are sticky. A start pulse in either state restarts the sequence exactly as from IDLE: done and err clear in the same cycle the state moves to LEN_HI.
- start is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- Timeout: the timer counts cycles in LEN_HI..CSUM without an accept and resets on every accept. Reaching TIMEOUT_CYCLES -> ERROR. If an accept and expiry occur in the same cycle, the accept wins.
- Throughput: one byte per cycle is sustained. in_ready never drops inside DATA, so a write pulse never stalls the stream.
- Address arithmetic: 32-bit, index width clog2(DEPTH+1). N == DEPTH is legal and writes up to BASE_ADDR + 4*(DEPTH-1), with no wrap.
- in_valid while in_ready=0 is not consumed. The upstream block holds the byte.

Decomposition:
- Shared package holds:
  - state enum: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
  - constant WORD_BYTES = 4.
  - constant LEN_BYTES = 2.
- One natural sub-module: imem_word_assembler, containing the byte counter, 32-bit shift register and word_valid pulse.
- FSM, checksum, timer and address counter stay in the top module.

Test Plan:
- Nominal load: start, then bytes 00 02 20 04 00 03 0C 00 00 03 28 -> writes (0x0, 0x20040003) and (0x4, 0x0C000003), each a 1-cycle mem_we the cycle after its 4th byte; then done=1, cpu_hold=0, err=0.
- Bad checksum: same stream with final byte 0x29 -> no extra writes after the two words; err=1, cpu_hold=1, done=0. A new start then clears err.
- Oversize length: DEPTH=256, length bytes 01 01 (N=257) -> ERROR immediately after LEN_LO, zero mem_we pulses, in_ready=0.
- Zero length and backpressure: stream 00 00 00 -> done=1 with no writes. Separately, a stream with in_valid gaps and in_valid toggling every cycle -> identical writes to the nominal case.
- Timeout and reset: TIMEOUT_CYCLES=16, stop the stream after 5 data bytes -> err=1 exactly 16 cycles after the last accept. Separately, assert reset mid-DATA -> all outputs return to reset values asynchronously, with no further mem_we.
- Full depth: DEPTH=4, N=4 -> last write at 0xC; start pulsed during DATA is ignored; the final write is issued after the CSUM transition.
